// File: rtl/ex_sched_pkg.sv
// ex_sched_pkg: unit/state encodings and default widths shared by the execute-unit scheduler
package ex_sched_pkg;
  localparam int XLEN_D = 32;
  localparam int RD_W_D = 5;
  typedef enum logic [1:0] {UNIT_ALU = 2'b00, UNIT_MDU = 2'b01, UNIT_FPU = 2'b10, UNIT_RSV = 2'b11} unit_e;
  typedef enum logic [1:0] {IDLE, WAIT_MDU, WAIT_FPU, DRAIN} state_e;
  function automatic logic is_multi(input logic [1:0] u);
    return u == UNIT_MDU || u == UNIT_FPU;
  endfunction
endpackage

// File: rtl/ex_unit_scheduler_if.sv
// ex_unit_scheduler_if: issue, unit launch/done and writeback bundle of the execute-unit scheduler
interface ex_unit_scheduler_if #(
  parameter int XLEN = ex_sched_pkg::XLEN_D,
  parameter int RD_W = ex_sched_pkg::RD_W_D
);
  logic            issue_valid;
  logic [1:0]      issue_unit;
  logic [RD_W-1:0] issue_rd;
  logic            flush;
  logic            mdu_start;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_result;
  logic            fpu_start;
  logic            fpu_done;
  logic [XLEN-1:0] fpu_result;
  logic            stall;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            busy_valid;
  logic [RD_W-1:0] busy_rd;
  logic            timeout_err;
  modport master (
    output issue_valid, issue_unit, issue_rd, flush, mdu_done, mdu_result, fpu_done, fpu_result,
    input  mdu_start, fpu_start, stall, wb_valid, wb_rd, wb_data, busy_valid, busy_rd, timeout_err
  );
  modport slave (
    input  issue_valid, issue_unit, issue_rd, flush, mdu_done, mdu_result, fpu_done, fpu_result,
    output mdu_start, fpu_start, stall, wb_valid, wb_rd, wb_data, busy_valid, busy_rd, timeout_err
  );
endinterface

// File: rtl/ex_sched_wb_reg.sv
// ex_sched_wb_reg: registered writeback capture; a done coinciding with flush is discarded
module ex_sched_wb_reg import ex_sched_pkg::*; #(
  parameter int XLEN = XLEN_D,
  parameter int RD_W = RD_W_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            done,
  input  logic            flush,
  input  logic [RD_W-1:0] rd,
  input  logic [XLEN-1:0] data,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data
);
  always_ff @(posedge clk)
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= done && !flush;
      if (done && !flush) begin
        wb_rd   <= rd;
        wb_data <= data;
      end
    end
endmodule

// File: rtl/ex_unit_scheduler.sv
// ex_unit_scheduler: launches MDU/FPU ops, stalls the front end until done, registers one writeback.
// Defining EX_SCHED_TIMEOUT_EN adds a sticky watchdog that abandons a wait after MAX_LAT cycles.
module ex_unit_scheduler import ex_sched_pkg::*; #(
  parameter int XLEN    = XLEN_D,
  parameter int RD_W    = RD_W_D,
  parameter int MAX_LAT = 64,
  parameter int CNT_W   = 7
) (
  input logic clk,
  input logic rst,
  ex_unit_scheduler_if.slave bus
);
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             unit_fpu;
  logic             in_wait;
  logic             launch;
  logic             done_u;
  logic             tmo;

  if (MAX_LAT >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow to count to MAX_LAT");
  end

  assign in_wait   = state == WAIT_MDU || state == WAIT_FPU;
  assign launch    = bus.issue_valid && is_multi(bus.issue_unit) && !bus.flush;
  // unit_fpu persists into DRAIN so only the abandoned unit's done ends it
  assign done_u    = unit_fpu ? bus.fpu_done : bus.mdu_done;
  assign bus.stall = in_wait || launch;
`ifdef EX_SCHED_TIMEOUT_EN
  assign tmo = state != IDLE && cnt >= CNT_W'(MAX_LAT);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk)
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      unit_fpu        <= 1'b0;
      bus.mdu_start   <= 1'b0;
      bus.fpu_start   <= 1'b0;
      bus.busy_valid  <= 1'b0;
      bus.busy_rd     <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.mdu_start <= 1'b0;
      bus.fpu_start <= 1'b0;
      cnt           <= &cnt ? cnt : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (launch) begin
            state          <= bus.issue_unit == UNIT_FPU ? WAIT_FPU : WAIT_MDU;
            unit_fpu       <= bus.issue_unit == UNIT_FPU;
            bus.mdu_start  <= bus.issue_unit == UNIT_MDU;
            bus.fpu_start  <= bus.issue_unit == UNIT_FPU;
            bus.busy_valid <= 1'b1;
            bus.busy_rd    <= bus.issue_rd;
          end
        end
        WAIT_MDU, WAIT_FPU:
          if (bus.flush || done_u || tmo) begin
            bus.busy_valid <= 1'b0;
            if (bus.flush && !done_u) state <= DRAIN;
            else begin
              state <= IDLE;
              cnt   <= '0;
            end
            if (!bus.flush && !done_u) bus.timeout_err <= 1'b1;
          end
        default:
          if (done_u || tmo) begin
            state <= IDLE;
            cnt   <= '0;
            if (!done_u) bus.timeout_err <= 1'b1;
          end
      endcase
    end

  ex_sched_wb_reg #(.XLEN(XLEN), .RD_W(RD_W)) u_wb (
    .clk     (clk),
    .rst     (rst),
    .done    (in_wait && done_u),
    .flush   (bus.flush),
    .rd      (bus.busy_rd),
    .data    (unit_fpu ? bus.fpu_result : bus.mdu_result),
    .wb_valid(bus.wb_valid),
    .wb_rd   (bus.wb_rd),
    .wb_data (bus.wb_data)
  );
endmodule

// File: tb/tb_ex_unit_scheduler.sv
// tb_ex_unit_scheduler: directed vector table, reset/watchdog sequences and a randomized model check
module tb_ex_unit_scheduler;
  import ex_sched_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_unit_scheduler_if #(.XLEN(32), .RD_W(5)) bus ();
  ex_unit_scheduler #(.XLEN(32), .RD_W(5), .MAX_LAT(8), .CNT_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic iv; logic [1:0] u; logic [4:0] rd; logic fl, md, fd; logic [31:0] mres, fres;
    logic stall, ms, fs, wbv; logic [4:0] wrd; logic [31:0] wd; logic bv;
  } vec_t;
  vec_t vecs[$];

  int errors = 0;
  int checks = 0;

  int pend;
  logic p_fpu, e_ms, e_fs, e_wbv, want, d;
  logic [4:0] p_rd, e_wrd;
  logic [31:0] e_wd;
  int age, first;
  int r_iv, r_u, r_rd, r_fl, r_md, r_fd;
  int unsigned r_mr, r_fr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int iv, u, rd, fl, md, fd, input int unsigned mr, fr);
    @(posedge clk);
    #1;
    bus.issue_valid = iv[0];
    bus.issue_unit  = u[1:0];
    bus.issue_rd    = rd[4:0];
    bus.flush       = fl[0];
    bus.mdu_done    = md[0];
    bus.fpu_done    = fd[0];
    bus.mdu_result  = mr;
    bus.fpu_result  = fr;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input int iv, u, rd, fl, md, fd, input int unsigned mr, fr,
                              input int st, ms, fs, wbv, wrd, input int unsigned wd, input int bv);
    vec_t v;
    v.iv = iv[0]; v.u = u[1:0]; v.rd = rd[4:0]; v.fl = fl[0]; v.md = md[0]; v.fd = fd[0];
    v.mres = mr; v.fres = fr; v.stall = st[0]; v.ms = ms[0]; v.fs = fs[0]; v.wbv = wbv[0];
    v.wrd = wrd[4:0]; v.wd = wd; v.bv = bv[0];
    return v;
  endfunction

  initial begin
    // MDU op, rd=5, done at cycle 4
    vecs.push_back(mk(1,1,5,0,0,0,0,0,           1,0,0,0,0,0,1'b0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,1,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,'h30,0,        1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,0,0,1,5,'h30,0));
    // FPU op, stray mdu_done at 3, fpu_done at 6
    vecs.push_back(mk(1,2,9,0,0,0,0,0,           1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,'hdead,0,      1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1,0,'h40400000,  1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,0,0,1,9,'h40400000,0));
    // flush at cycle 2 of WAIT_MDU, mdu_done at 5, ALU issue at 6
    vecs.push_back(mk(1,1,7,0,0,0,0,0,           1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,1,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,1,0,0,0,0,           1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,'hbad,0,       0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,3,0,0,0,0,0,           0,0,0,0,0,0,0));
    // DRAIN with FPU issue held; stray fpu_done ignored; launch after IDLE re-entry
    vecs.push_back(mk(1,1,3,0,0,0,0,0,           1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,1,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,1,0,0,0,0,           1,0,0,0,0,0,1));
    vecs.push_back(mk(1,2,4,0,0,0,0,0,           1,0,0,0,0,0,0));
    vecs.push_back(mk(1,2,4,0,0,1,0,'h99,        1,0,0,0,0,0,0));
    vecs.push_back(mk(1,2,4,0,1,0,'h88,0,        1,0,0,0,0,0,0));
    vecs.push_back(mk(1,2,4,0,0,0,0,0,           1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1,0,'h11,        1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,0,0,1,4,'h11,0));
    // rd=0, then done+flush together, then immediate relaunch proves IDLE
    vecs.push_back(mk(1,1,0,0,0,0,0,0,           1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,1,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,'h77,0,        1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,0,0,1,0,'h77,0));
    vecs.push_back(mk(1,2,6,0,0,0,0,0,           1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,1,0,1,0,'h55,        1,0,0,0,0,0,1));
    vecs.push_back(mk(1,1,8,0,0,0,0,0,           1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,1,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,1,0,           1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,0,0,1,8,1,0));
    // reserved unit and flushed issue are no-ops
    vecs.push_back(mk(1,3,2,0,0,0,0,0,           0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,2,1,0,0,0,0,           0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,0,0,0,0,0,0));

    bus.issue_valid = 1'b0; bus.issue_unit = 2'd0; bus.issue_rd = 5'd0; bus.flush = 1'b0;
    bus.mdu_done = 1'b0; bus.fpu_done = 1'b0; bus.mdu_result = '0; bus.fpu_result = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", 32'(bus.stall), 0);
    chk("reset mdu_start", 32'(bus.mdu_start), 0);
    chk("reset fpu_start", 32'(bus.fpu_start), 0);
    chk("reset wb_valid", 32'(bus.wb_valid), 0);
    chk("reset wb_rd", 32'(bus.wb_rd), 0);
    chk("reset wb_data", bus.wb_data, 0);
    chk("reset busy_valid", 32'(bus.busy_valid), 0);
    chk("reset busy_rd", 32'(bus.busy_rd), 0);
    chk("reset timeout_err", 32'(bus.timeout_err), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(int'(vecs[i].iv), int'(vecs[i].u), int'(vecs[i].rd), int'(vecs[i].fl),
            int'(vecs[i].md), int'(vecs[i].fd), vecs[i].mres, vecs[i].fres);
      chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d mdu_start", i), 32'(bus.mdu_start), 32'(vecs[i].ms));
      chk($sformatf("v%0d fpu_start", i), 32'(bus.fpu_start), 32'(vecs[i].fs));
      chk($sformatf("v%0d wb_valid", i), 32'(bus.wb_valid), 32'(vecs[i].wbv));
      chk($sformatf("v%0d busy_valid", i), 32'(bus.busy_valid), 32'(vecs[i].bv));
      if (vecs[i].wbv) begin
        chk($sformatf("v%0d wb_rd", i), 32'(bus.wb_rd), 32'(vecs[i].wrd));
        chk($sformatf("v%0d wb_data", i), bus.wb_data, vecs[i].wd);
      end
    end

    // reset in the middle of WAIT_FPU, then a late fpu_done
    drive(1,2,12,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    chk("mid fpu_start", 32'(bus.fpu_start), 1);
    chk("mid busy_rd", 32'(bus.busy_rd), 12);
    rst = 1'b1;
    drive(0,0,0,0,0,0,0,0);
    rst = 1'b0;
    drive(0,0,0,0,0,1,0,'habc);
    chk("rstmid stall", 32'(bus.stall), 0);
    chk("rstmid busy_valid", 32'(bus.busy_valid), 0);
    chk("rstmid busy_rd", 32'(bus.busy_rd), 0);
    chk("rstmid wb_rd", 32'(bus.wb_rd), 0);
    chk("rstmid wb_data", bus.wb_data, 0);
    drive(0,0,0,0,0,0,0,0);
    chk("rstmid late wb_valid", 32'(bus.wb_valid), 0);
    chk("rstmid late stall", 32'(bus.stall), 0);

    // long wait with no done
    drive(1,1,13,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    first = 0;
    for (int k = 2; k <= 20; k++) begin
      drive(0,0,0,0,0,0,0,0);
      if (bus.timeout_err && first == 0) first = k;
    end
`ifdef EX_SCHED_TIMEOUT_EN
    chk("timeout first cycle", 32'(first), 10);
    chk("timeout stall", 32'(bus.stall), 0);
    chk("timeout busy_valid", 32'(bus.busy_valid), 0);
    drive(0,0,0,0,1,0,'h5a,0);
    drive(0,0,0,0,0,0,0,0);
    chk("timeout stray wb_valid", 32'(bus.wb_valid), 0);
    chk("timeout sticky", 32'(bus.timeout_err), 1);
`else
    chk("no watchdog err", 32'(first), 0);
    chk("long wait stall", 32'(bus.stall), 1);
    chk("long wait busy_valid", 32'(bus.busy_valid), 1);
    drive(0,0,0,0,1,0,'h5a,0);
    drive(0,0,0,0,0,0,0,0);
    chk("long wait wb_valid", 32'(bus.wb_valid), 1);
    chk("long wait wb_rd", 32'(bus.wb_rd), 13);
    chk("long wait wb_data", bus.wb_data, 'h5a);
`endif
    rst = 1'b1;
    drive(0,0,0,0,0,0,0,0);
    rst = 1'b0;
    chk("err cleared by rst", 32'(bus.timeout_err), 0);

    // randomized traffic against a transaction-level model: 0 none, 1 live op, 2 abandoned op
    pend = 0; age = 0; p_fpu = 1'b0; p_rd = '0;
    e_ms = 1'b0; e_fs = 1'b0; e_wbv = 1'b0; e_wrd = '0; e_wd = '0;
    for (int n = 0; n < 600; n++) begin
      r_iv = int'($urandom_range(0, 1));
      r_u  = int'($urandom_range(0, 3));
      r_rd = int'($urandom_range(0, 31));
      r_fl = int'($urandom_range(0, 7) == 0);
      r_md = int'($urandom_range(0, 3) == 0);
      r_fd = int'($urandom_range(0, 3) == 0);
      r_mr = $urandom;
      r_fr = $urandom;
      if (pend != 0 && age >= 5) begin
        if (p_fpu) r_fd = 1;
        else r_md = 1;
      end
      drive(r_iv, r_u, r_rd, r_fl, r_md, r_fd, r_mr, r_fr);
      want = r_iv == 1 && (r_u == 1 || r_u == 2) && r_fl == 0;
      chk("rnd stall", 32'(bus.stall), 32'(pend == 1 || want));
      chk("rnd mdu_start", 32'(bus.mdu_start), 32'(e_ms));
      chk("rnd fpu_start", 32'(bus.fpu_start), 32'(e_fs));
      chk("rnd wb_valid", 32'(bus.wb_valid), 32'(e_wbv));
      chk("rnd busy_valid", 32'(bus.busy_valid), 32'(pend == 1));
      if (e_wbv) begin
        chk("rnd wb_rd", 32'(bus.wb_rd), 32'(e_wrd));
        chk("rnd wb_data", bus.wb_data, e_wd);
      end
      if (pend == 1) chk("rnd busy_rd", 32'(bus.busy_rd), 32'(p_rd));
      d = p_fpu ? r_fd[0] : r_md[0];
      e_ms = 1'b0; e_fs = 1'b0; e_wbv = 1'b0;
      age++;
      if (pend == 0) begin
        if (want) begin
          pend = 1; age = 0;
          p_fpu = r_u == 2; p_rd = r_rd[4:0];
          e_ms = r_u == 1; e_fs = r_u == 2;
        end
      end else if (pend == 1) begin
        if (r_fl == 1) pend = d ? 0 : 2;
        else if (d) begin
          e_wbv = 1'b1; e_wrd = p_rd; e_wd = p_fpu ? r_fr : r_mr;
          pend = 0;
        end
      end else if (d) pend = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_unit_scheduler.md
Name: ex_unit_scheduler

Overview:
- Sequences the multi-cycle execute-stage units (MDU: mul/div; FPU) of the 5-stage RV32IMF pipeline.
- Launches the selected unit with a one-cycle start pulse and holds the front of the pipeline (stall) until the unit reports done.
- Drives a single registered result/writeback port and exposes the pending destination register to hazard detection.
- Single-cycle ALU ops pass through untouched.

Parameters:
- XLEN, 32, data width of unit results and wb_data
- RD_W, 5, register-index width
- MAX_LAT, 64, watchdog limit in WAIT cycles; used only when TIMEOUT_EN is defined
- CNT_W, 7, width of the latency counter; must satisfy 2^CNT_W > MAX_LAT

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction present in execute this cycle
- issue_unit  in  2  00 ALU, 01 MDU, 10 FPU, 11 reserved (treated as ALU)
- issue_rd  in  RD_W  destination register of the issuing instruction
- flush  in  1  branch/jump flush from execute
- mdu_start  out  1  one-cycle launch pulse to the MDU
- mdu_done  in  1  MDU result valid (single-cycle pulse)
- mdu_result  in  XLEN  MDU result
- fpu_start  out  1  one-cycle launch pulse to the FPU
- fpu_done  in  1  FPU result valid (single-cycle pulse)
- fpu_result  in  XLEN  FPU result
- stall  out  1  freeze fetch/decode; insert NOP into execute
- wb_valid  out  1  registered result valid (one-cycle pulse)
- wb_rd  out  RD_W  destination for wb_data
- wb_data  out  XLEN  captured unit result
- busy_valid  out  1  a multi-cycle op is outstanding
- busy_rd  out  RD_W  its destination; for hazard detection
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; all registered outputs 0 (mdu_start, fpu_start, wb_valid, wb_rd, wb_data, busy_valid, busy_rd, timeout_err); counter 0.
- Reset mid-operation: any in-flight unit result arriving after reset is ignored, because done is only observed in WAIT_*/DRAIN.
- States: IDLE, WAIT_MDU, WAIT_FPU, DRAIN.
- IDLE:
  - issue_valid & unit in {01,10} & !flush: assert stall combinationally this cycle. Next cycle: start pulse to the selected unit, latch rd into busy_rd, busy_valid=1, enter WAIT_MDU/WAIT_FPU.
  - ALU/reserved issue, or flush: no action.
- WAIT_x:
  - stall=1 every cycle.
  - Only the active unit's done is honoured; the other unit's done is ignored.
  - On done: capture result into wb_data, wb_rd=busy_rd, wb_valid=1 on the next cycle; busy_valid->0; return to IDLE; stall deasserts in that next cycle.
  - Latency: issue at cycle 0, start at cycle 1, done at cycle N>=2, wb_valid at N+1.
- Flush in WAIT_x: enter DRAIN, stall->0, busy_valid->0, no writeback.
- DRAIN:
  - Waits for the abandoned unit's done, then goes to IDLE. The result is discarded.
  - A multi-cycle issue arriving in DRAIN holds stall=1 until the done cycle. It is then launched from IDLE on the following cycle, provided issue_valid is still asserted.
- rd=0: sequenced normally; wb_valid asserted with wb_rd=0 (register file ignores x0).
- Simultaneous done and flush in WAIT_x: flush wins; result discarded, state goes to IDLE directly.
- Counter increments in WAIT_x/DRAIN and clears on entry to IDLE; it saturates at all-ones.

Optional Feature:
- Macro: EX_SCHED_TIMEOUT_EN.
- Defined:
  - When the counter reaches MAX_LAT in WAIT_x or DRAIN, set timeout_err (sticky until rst), go to IDLE, drop stall and busy_valid, no writeback.
  - A later stray done is ignored.
- Undefined: no watchdog compare; waits indefinitely; timeout_err tied 0; counter still present.

Decomposition:
- Shared package ex_sched_pkg:
  - unit encodings UNIT_ALU/UNIT_MDU/UNIT_FPU
  - state enum
  - XLEN/RD_W defaults
- One natural sub-module, ex_sched_wb_reg: registered result/rd/valid capture, including the flush-discard gating.
- FSM and counter stay in the top level.

Test Plan:
- MDU op: issue_unit=01, rd=5, mdu_done at cycle 4 with 0x0000_0030 -> mdu_start pulse at cycle 1; stall high cycles 0-4; wb_valid/wb_rd=5/wb_data=0x30 at cycle 5; busy_valid low at cycle 5.
- FPU op with a stray mdu_done at cycle 3 and fpu_done at cycle 6 -> mdu_done ignored; writeback of fpu_result at cycle 7 only.
- Flush at cycle 2 of a WAIT_MDU, mdu_done at cycle 5 -> stall low from cycle 3; no wb_valid; state IDLE at cycle 6.
- DRAIN plus new FPU issue -> stall held until the drain done; fpu_start exactly one cycle after IDLE is re-entered.
- rst asserted mid-WAIT_FPU, then fpu_done -> all outputs 0; no wb_valid.
- EX_SCHED_TIMEOUT_EN, MAX_LAT=8, no done -> timeout_err=1 after 8 WAIT cycles; stall released; timeout_err stays 1 until rst.
